// File: rtl/capture_sequencer.sv
// capture_sequencer: arbitrates two decoder byte strobes into a capture RAM,
// waits for an optional trigger byte, captures a programmed length and serves read-out.
module capture_sequencer #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig_en,
    input  logic [7:0]    trig_byte,
    input  logic [CW-1:0] cap_len,
    input  logic          a_valid,
    input  logic [7:0]    a_data,
    input  logic          b_valid,
    input  logic [7:0]    b_data,
    output logic          dec_detect_only,
    output logic [1:0]    state,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic          rd_en,
    output logic [8:0]    rd_data,
    output logic          rd_valid
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] len_q, len_d, count_q, count_d, rd_ptr_q, rd_ptr_d, eff_len;
    logic          ovf_q, ovf_d, rr_b_q, rr_b_d, rd_valid_q, rd_valid_d;
    logic          a_full_q, a_full_d, b_full_q, b_full_d;
    logic [7:0]    a_hold_q, a_hold_d, b_hold_q, b_hold_d;
    logic [8:0]    rd_data_q, rd_data_d, gbyte;
    logic [8:0]    mem [DEPTH];
    logic          active, ga, gb, gnt, hit, we;
    logic [AW-1:0] waddr;
    // rr_b_q set means port B wins the next tie
    assign active  = (state_q == ARMED) || (state_q == CAPTURE);
    assign ga      = a_full_q && (!b_full_q || !rr_b_q);
    assign gb      = b_full_q && !ga;
    assign gnt     = ga || gb;
    assign gbyte   = ga ? {1'b0, a_hold_q} : {1'b1, b_hold_q};
    assign hit     = !trig_en || (gbyte[7:0] == trig_byte);
    assign eff_len = (cap_len == '0 || cap_len > CW'(DEPTH)) ? CW'(DEPTH) : cap_len;
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        rr_b_d     = rr_b_q;
        a_full_d   = a_full_q;
        a_hold_d   = a_hold_q;
        b_full_d   = b_full_q;
        b_hold_d   = b_hold_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we         = 1'b0;
        waddr      = count_q[AW-1:0];
        if (active) begin
            a_full_d = a_valid || (a_full_q && !ga);
            a_hold_d = (a_valid && (!a_full_q || ga)) ? a_data : a_hold_q;
            b_full_d = b_valid || (b_full_q && !gb);
            b_hold_d = (b_valid && (!b_full_q || gb)) ? b_data : b_hold_q;
            ovf_d    = ovf_q || (a_valid && a_full_q && !ga) || (b_valid && b_full_q && !gb);
            rr_b_d   = gnt ? ga : rr_b_q;
        end
        case (state_q)
            ARMED: if (gnt && hit) begin
                we      = 1'b1;
                waddr   = '0;
                count_d = CW'(1);
                if (len_q == CW'(1)) state_d = DONE;
                else state_d = CAPTURE;
            end
            CAPTURE: if (gnt) begin
                we      = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q + CW'(1) == len_q) state_d = DONE;
            end
            DONE: if (rd_en && rd_ptr_q < count_q) begin
                rd_data_d  = mem[rd_ptr_q[AW-1:0]];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + CW'(1);
            end
            default: ;
        endcase
        // leftover held bytes are discarded once the capture completes
        if (state_d == DONE) begin
            a_full_d = 1'b0;
            b_full_d = 1'b0;
        end
        if (arm && (state_q == IDLE || state_q == DONE)) begin
            state_d    = ARMED;
            len_d      = eff_len;
            count_d    = '0;
            ovf_d      = 1'b0;
            rd_ptr_d   = '0;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
        end
        if (abort) begin
            state_d    = IDLE;
            len_d      = len_q;
            count_d    = count_q;
            ovf_d      = ovf_q;
            rr_b_d     = rr_b_q;
            rd_ptr_d   = rd_ptr_q;
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            we         = 1'b0;
        end
        if (abort || state_d == ARMED && state_q != ARMED) begin
            a_full_d = 1'b0;
            b_full_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rr_b_q     <= 1'b0;
            a_full_q   <= 1'b0;
            a_hold_q   <= '0;
            b_full_q   <= 1'b0;
            b_hold_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rr_b_q     <= rr_b_d;
            a_full_q   <= a_full_d;
            a_hold_q   <= a_hold_d;
            b_full_q   <= b_full_d;
            b_hold_q   <= b_hold_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= gbyte;
    end
    assign dec_detect_only = (state_q == IDLE) || (state_q == DONE);
    assign state           = state_q;
    assign count           = count_q;
    assign overflow        = ovf_q;
    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: scoreboard bench; expected entries are queued as bytes are driven
// and popped as the read-out port returns them.
module tb_capture_sequencer;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    logic          clk = 1'b0, rst_n = 1'b0, arm = 1'b0, abort = 1'b0, trig_en = 1'b0;
    logic [7:0]    trig_byte = '0, a_data = '0, b_data = '0;
    logic [CW-1:0] cap_len = '0;
    logic          a_valid = 1'b0, b_valid = 1'b0, rd_en = 1'b0;
    logic          dec_detect_only, overflow, rd_valid;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [8:0]    rd_data;
    logic [8:0]    exp_q [$];
    logic [7:0]    t2 [6] = '{8'h11, 8'hA5, 8'h22, 8'h33, 8'h44, 8'h55};
    int            n_chk = 0, n_pass = 0;

    capture_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_en(trig_en),
        .trig_byte(trig_byte), .cap_len(cap_len), .a_valid(a_valid), .a_data(a_data),
        .b_valid(b_valid), .b_data(b_data), .dec_detect_only(dec_detect_only),
        .state(state), .count(count), .overflow(overflow), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic start(input logic te, input logic [7:0] tbv, input logic [CW-1:0] len);
        trig_en = te; trig_byte = tbv; cap_len = len; arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_state", state, 1);
        chk("armed_det", dec_detect_only, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (state != 2'd3 && n < 64) begin
            tick();
            n++;
        end
        chk(tag, state, 3);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            rd_en = 1'b1;
            tick();
            chk({tag, "_valid"}, rd_valid, 1);
            chk({tag, "_data"}, rd_data, exp_q.pop_front());
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_past_end"}, rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_det", dec_detect_only, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0);
        rst_n = 1'b1;
        tick();
        strobe(1'b1, 8'h5A, 1'b1, 8'h3C);
        tick();
        chk("idle_count", count, 0);
        chk("idle_state", state, 0);

        // simultaneous strobes, pointer at A after reset
        start(1'b0, 8'h00, 5'd2);
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 8'h02});
        strobe(1'b1, 8'h01, 1'b1, 8'h02);
        tick();
        chk("sim_trig_state", state, 2);
        chk("sim_trig_count", count, 1);
        tick();
        chk("sim_done", state, 3);
        chk("sim_count", count, 2);
        chk("sim_ovf", overflow, 0);
        drain("sim");

        // trigger match on 0xA5, length 4
        start(1'b1, 8'hA5, 5'd4);
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33});
        exp_q.push_back({1'b0, 8'h44});
        for (int i = 0; i < 6; i++) strobe(1'b1, t2[i], 1'b0, 8'h00);
        wait_done("trig_done");
        chk("trig_count", count, 4);
        chk("trig_ovf", overflow, 0);
        chk("trig_det", dec_detect_only, 1);
        drain("trig");

        // overflow: A on 3 cycles, B on 5; last grant was A so B wins first tie
        start(1'b0, 8'h00, 5'd5);
        exp_q.push_back({1'b1, 8'hB1});
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b1, 8'hB2});
        exp_q.push_back({1'b0, 8'hA3});
        exp_q.push_back({1'b1, 8'hB4});
        strobe(1'b1, 8'hA1, 1'b1, 8'hB1);
        strobe(1'b1, 8'hA2, 1'b1, 8'hB2);
        strobe(1'b1, 8'hA3, 1'b1, 8'hB3);
        strobe(1'b0, 8'h00, 1'b1, 8'hB4);
        strobe(1'b0, 8'h00, 1'b1, 8'hB5);
        wait_done("ovf_done");
        chk("ovf_count", count, 5);
        chk("ovf_flag", overflow, 1);
        drain("ovf");

        // cap_len 0 means full depth
        start(1'b0, 8'h00, 5'd0);
        for (int i = 0; i < 20; i++) begin
            if (i < DEPTH) exp_q.push_back({1'b0, 8'(8'h30 + i)});
            strobe(1'b1, 8'(8'h30 + i), 1'b0, 8'h00);
        end
        wait_done("full_done");
        chk("full_count", count, 16);
        drain("full");

        // abort mid-capture
        start(1'b0, 8'h00, 5'd8);
        strobe(1'b1, 8'hC1, 1'b0, 8'h00);
        strobe(1'b1, 8'hC2, 1'b0, 8'h00);
        strobe(1'b1, 8'hC3, 1'b0, 8'h00);
        tick();
        chk("abt_pre_state", state, 2);
        chk("abt_pre_count", count, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_state", state, 0);
        chk("abt_det", dec_detect_only, 1);
        chk("abt_count", count, 3);

        // asynchronous reset mid-capture
        start(1'b0, 8'h00, 5'd8);
        strobe(1'b1, 8'hD1, 1'b0, 8'h00);
        strobe(1'b1, 8'hD2, 1'b0, 8'h00);
        tick();
        chk("ar_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_det", dec_detect_only, 1);
        chk("ar_count", count, 0);
        chk("ar_ovf", overflow, 0);
        chk("ar_rdv", rd_valid, 0);
        chk("ar_rdd", rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start(1'b0, 8'h00, 5'd3);
        exp_q.push_back({1'b0, 8'h71});
        exp_q.push_back({1'b1, 8'h72});
        exp_q.push_back({1'b0, 8'h73});
        strobe(1'b1, 8'h71, 1'b1, 8'h72);
        strobe(1'b1, 8'h73, 1'b0, 8'h00);
        wait_done("re_done");
        chk("re_count", count, 3);
        chk("re_ovf", overflow, 0);
        drain("re");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
